calc_control_fsm: RTL

Calculator control stage directly downstream of the registered key-decoder stage. Consumes the registered key flags (`is_num`, `is_op`, `is_eq`, `clear`, `btn_pressed`) and values (`num_val`, `op_val`). Assembles two unsigned decimal operands and an operator, executes the operation in a dedicated cycle, and presents the value to display plus status flags to the display driver.

---
 rtl/calc_control_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/calc_control_fsm.sv
// Calculator control stage: assembles two decimal operands and an operator from
// registered key flags, executes in a dedicated cycle and drives the display value.
module calc_control_fsm #(
    parameter int DIGITS = 3,
    parameter int OPW    = 10,
    parameter int RES_W  = 2*OPW+1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_pressed,
    input  logic             is_num,
    input  logic             is_op,
    input  logic             is_eq,
    input  logic             clear,
    input  logic [3:0]       num_val,
    input  logic [1:0]       op_val,
    output logic [RES_W-1:0] disp_val,
    output logic             result_valid,
    output logic             error,
    output logic             entering_b,
    output logic             key_ack
);

    typedef enum logic [2:0] {
        S_ENTER_A, S_OP_WAIT, S_ENTER_B, S_EXEC, S_RESULT, S_ERROR
    } state_t;

    localparam int            CW       = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] DCNT_MAX = CW'(DIGITS);
    localparam logic [1:0]    OP_ADD   = 2'b00;
    localparam logic [1:0]    OP_SUB   = 2'b01;
    localparam logic [1:0]    OP_MUL   = 2'b10;

    state_t            state_q, state_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [CW-1:0]     dcnt_a_q, dcnt_a_d, dcnt_b_q, dcnt_b_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              btn_prev_q;

    logic              key_event, digit_ok, ack_d;
    logic [OPW-1:0]    digit_ext;
    logic signed [RES_W-1:0] a_ext, b_ext;
    logic [RES_W-1:0]  disp_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        dcnt_a_d  = dcnt_a_q;
        dcnt_b_d  = dcnt_b_q;
        res_d     = res_q;
        ack_d     = 1'b0;
        key_event = btn_pressed & ~btn_prev_q;
        digit_ok  = (num_val <= 4'd9);
        digit_ext = OPW'(num_val);
        a_ext     = {{(RES_W-OPW){1'b0}}, a_q};
        b_ext     = {{(RES_W-OPW){1'b0}}, b_q};

        // Only the highest-priority flag of an event is considered.
        if (key_event && state_q != S_EXEC) begin
            if (clear) begin
                state_d  = S_ENTER_A;
                a_d      = '0;
                b_d      = '0;
                op_d     = '0;
                dcnt_a_d = '0;
                dcnt_b_d = '0;
                res_d    = '0;
                ack_d    = 1'b1;
            end else if (is_eq) begin
                if (state_q == S_OP_WAIT) begin
                    b_d     = '0;
                    state_d = S_EXEC;
                    ack_d   = 1'b1;
                end else if (state_q == S_ENTER_B) begin
                    state_d = S_EXEC;
                    ack_d   = 1'b1;
                end
            end else if (is_op) begin
                if (state_q == S_ENTER_A || state_q == S_OP_WAIT) begin
                    op_d    = op_val;
                    state_d = S_OP_WAIT;
                    ack_d   = 1'b1;
                end
            end else if (is_num && digit_ok) begin
                case (state_q)
                    S_ENTER_A: if (dcnt_a_q < DCNT_MAX) begin
                        a_d      = a_q * OPW'(10) + digit_ext;
                        dcnt_a_d = dcnt_a_q + CW'(1);
                        ack_d    = 1'b1;
                    end
                    S_OP_WAIT: begin
                        b_d      = digit_ext;
                        dcnt_b_d = CW'(1);
                        state_d  = S_ENTER_B;
                        ack_d    = 1'b1;
                    end
                    S_ENTER_B: if (dcnt_b_q < DCNT_MAX) begin
                        b_d      = b_q * OPW'(10) + digit_ext;
                        dcnt_b_d = dcnt_b_q + CW'(1);
                        ack_d    = 1'b1;
                    end
                    S_RESULT: begin
                        a_d      = digit_ext;
                        dcnt_a_d = CW'(1);
                        b_d      = '0;
                        dcnt_b_d = '0;
                        state_d  = S_ENTER_A;
                        ack_d    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (state_q == S_EXEC) begin
            state_d = S_RESULT;
            case (op_q)
                OP_ADD:  res_d = a_ext + b_ext;
                OP_SUB:  res_d = a_ext - b_ext;
                OP_MUL:  res_d = a_ext * b_ext;
                default: begin
                    if (b_q == '0) state_d = S_ERROR;
                    else           res_d   = a_ext / b_ext;
                end
            endcase
        end

        // Outputs are derived from next-state values so they line up with the state.
        case (state_d)
            S_ENTER_A, S_OP_WAIT: disp_d = {{(RES_W-OPW){1'b0}}, a_d};
            S_ENTER_B:            disp_d = {{(RES_W-OPW){1'b0}}, b_d};
            S_RESULT:             disp_d = res_d;
            default:              disp_d = disp_val;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_ENTER_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            dcnt_a_q     <= '0;
            dcnt_b_q     <= '0;
            res_q        <= '0;
            btn_prev_q   <= 1'b1;
            disp_val     <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            entering_b   <= 1'b0;
            key_ack      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            dcnt_a_q     <= dcnt_a_d;
            dcnt_b_q     <= dcnt_b_d;
            res_q        <= res_d;
            btn_prev_q   <= btn_pressed;
            disp_val     <= disp_d;
            result_valid <= (state_d == S_RESULT);
            error        <= (state_d == S_ERROR);
            entering_b   <= (state_d == S_OP_WAIT) || (state_d == S_ENTER_B);
            key_ack      <= ack_d;
        end
    end

endmodule
